// File: rtl/wavegen_dds_if.sv
// Configuration and sample bus between a wavegen_dds source and its consumer.
// The master drives run control and waveform settings; the slave returns DAC codes.
interface wavegen_dds_if;
  logic        enable;
  logic        sync;
  logic [1:0]  mode_a;
  logic [1:0]  mode_b;
  logic [31:0] freq_a;
  logic [31:0] freq_b;
  logic [11:0] amp_a;
  logic [11:0] amp_b;
  logic [11:0] offset_a;
  logic [11:0] offset_b;
  logic [11:0] dacA_out;
  logic [11:0] dacB_out;
  logic        sample_valid;

  modport master (
    output enable, sync, mode_a, mode_b, freq_a, freq_b,
           amp_a, amp_b, offset_a, offset_b,
    input  dacA_out, dacB_out, sample_valid
  );

  modport slave (
    input  enable, sync, mode_a, mode_b, freq_a, freq_b,
           amp_a, amp_b, offset_a, offset_b,
    output dacA_out, dacB_out, sample_valid
  );
endinterface

// File: rtl/wavegen_dds.sv
// Dual-channel DDS waveform source: sample-rate tick, 32-bit phase accumulators,
// DC/square/saw/triangle shaping, amplitude/offset scaling and saturation to 12-bit DAC codes.
module wavegen_dds #(
  parameter int unsigned SAMPLE_DIV = 2000
) (
  input logic          clk,
  input logic          rst_n,
  wavegen_dds_if.slave bus
);

  localparam int unsigned     CW       = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [11:0]     MIDSCALE = 12'd2048;

  typedef enum logic [1:0] {
    MODE_DC     = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_TRI    = 2'd3
  } mode_e;

  // Subtracting 2048 from a 12-bit code is the same as flipping its MSB.
  function automatic logic signed [11:0] raw_sample(mode_e mode, logic [11:0] p);
    logic [10:0] t;
    t = p[11] ? ~p[10:0] : p[10:0];
    case (mode)
      MODE_SQUARE: raw_sample = p[11] ? 12'sh800 : 12'sh7FF;
      MODE_SAW:    raw_sample = $signed(p ^ 12'h800);
      MODE_TRI:    raw_sample = $signed({t, 1'b0} ^ 12'h800);
      default:     raw_sample = '0;
    endcase
  endfunction

  function automatic logic [11:0] scale_sat(logic signed [11:0] r, logic [11:0] amp,
                                            logic [11:0] offset);
    logic signed [24:0] prod;
    logic signed [13:0] s;
    logic signed [13:0] y;
    prod = r * $signed({1'b0, amp});
    s    = 14'(prod >>> 11);
    y    = $signed({2'b00, offset}) + s;
    if (y[13])               scale_sat = 12'd0;
    else if (y > 14'sd4095)  scale_sat = 12'd4095;
    else                     scale_sat = y[11:0];
  endfunction

  mode_e       mode_in   [2];
  logic [31:0] freq_in   [2];
  logic [11:0] amp_in    [2];
  logic [11:0] offset_in [2];

  assign mode_in[0]   = mode_e'(bus.mode_a);
  assign mode_in[1]   = mode_e'(bus.mode_b);
  assign freq_in[0]   = bus.freq_a;
  assign freq_in[1]   = bus.freq_b;
  assign amp_in[0]    = bus.amp_a;
  assign amp_in[1]    = bus.amp_b;
  assign offset_in[0] = bus.offset_a;
  assign offset_in[1] = bus.offset_b;

  logic [CW-1:0]      cnt_q,   cnt_d;
  logic               tick;
  logic [31:0]        phase_q [2], phase_d [2];
  logic [11:0]        p_q     [2], p_d     [2];
  mode_e              mode_q  [2], mode_d  [2];
  logic [11:0]        amp1_q  [2], amp1_d  [2];
  logic [11:0]        off1_q  [2], off1_d  [2];
  logic signed [11:0] r_q     [2], r_d     [2];
  logic [11:0]        amp2_q  [2], amp2_d  [2];
  logic [11:0]        off2_q  [2], off2_d  [2];
  logic [11:0]        dac_q   [2], dac_d   [2];
  logic               v1_q, v1_d, v2_q, v2_d, valid_q, valid_d;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so any path that skips an assignment holds state rather than inferring a latch.
    cnt_d   = cnt_q;
    phase_d = phase_q;
    p_d     = p_q;
    mode_d  = mode_q;
    amp1_d  = amp1_q;
    off1_d  = off1_q;
    r_d     = r_q;
    amp2_d  = amp2_q;
    off2_d  = off2_q;
    dac_d   = dac_q;

    tick    = bus.enable && (cnt_q == CNT_LAST);
    v1_d    = tick;
    v2_d    = v1_q;
    valid_d = v2_q;

    if (!bus.enable || tick) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;

    for (int ch = 0; ch < 2; ch++) begin
      // sync overrides the tick: both the captured phase and the new phase are zero.
      if (bus.sync)  phase_d[ch] = '0;
      else if (tick) phase_d[ch] = phase_q[ch] + freq_in[ch];

      if (tick) begin
        p_d[ch]    = bus.sync ? 12'd0 : phase_q[ch][31:20];
        mode_d[ch] = mode_in[ch];
        amp1_d[ch] = amp_in[ch];
        off1_d[ch] = offset_in[ch];
      end

      if (v1_q) begin
        r_d[ch]    = raw_sample(mode_q[ch], p_q[ch]);
        amp2_d[ch] = amp1_q[ch];
        off2_d[ch] = off1_q[ch];
      end

      if (v2_q) dac_d[ch] = scale_sat(r_q[ch], amp2_q[ch], off2_q[ch]);
    end
  end

  // NOTE: the whole pipeline is reset, not just the valid bits, so a sample aborted by reset can never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        phase_q[ch] <= '0;
        p_q[ch]     <= '0;
        mode_q[ch]  <= MODE_DC;
        amp1_q[ch]  <= '0;
        off1_q[ch]  <= '0;
        r_q[ch]     <= '0;
        amp2_q[ch]  <= '0;
        off2_q[ch]  <= '0;
        dac_q[ch]   <= MIDSCALE;
      end
    end else begin
      // NOTE: non-blocking assignments make every register sample its _d at the same edge.
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      amp1_q  <= amp1_d;
      off1_q  <= off1_d;
      r_q     <= r_d;
      amp2_q  <= amp2_d;
      off2_q  <= off2_d;
      dac_q   <= dac_d;
    end
  end

  assign bus.dacA_out     = dac_q[0];
  assign bus.dacB_out     = dac_q[1];
  assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_wavegen_dds.sv
// Scoreboard bench for wavegen_dds with SAMPLE_DIV=4: directed scenarios push expected
// (code A, code B, strobe cycle) entries; a monitor pops and compares on every strobe.
module tb_wavegen_dds;
  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wavegen_dds_if bus ();

  wavegen_dds #(.SAMPLE_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   rel      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_a   = 2048;
  int   last_b   = 2048;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d after release)", name, act, exp, cyc - rel);
    end
  endtask

  // Monitor: strobes are popped and compared; between strobes the outputs must hold.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      last_a = 2048;
      last_b = 2048;
    end
    if (bus.sample_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", int'(bus.sample_valid), 0);
        last_a = int'(bus.dacA_out);
        last_b = int'(bus.dacB_out);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_cycle", cyc - rel, mon_e.cyc - rel);
        check("dacA", int'(bus.dacA_out), mon_e.a);
        check("dacB", int'(bus.dacB_out), mon_e.b);
        last_a = mon_e.a;
        last_b = mon_e.b;
      end
    end else begin
      check("holdA", int'(bus.dacA_out), last_a);
      check("holdB", int'(bus.dacB_out), last_b);
    end
  end

  task automatic start_scn(input logic [1:0] ma, input logic [31:0] fa, input logic [11:0] aa,
                           input logic [11:0] oa, input logic [1:0] mb, input logic [31:0] fb,
                           input logic [11:0] ab, input logic [11:0] ob);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.enable   = 1'b1;
    bus.sync     = 1'b0;
    bus.mode_a   = ma;
    bus.freq_a   = fa;
    bus.amp_a    = aa;
    bus.offset_a = oa;
    bus.mode_b   = mb;
    bus.freq_b   = fb;
    bus.amp_b    = ab;
    bus.offset_b = ob;
    @(negedge clk);
    rst_n = 1'b1;
    rel   = cyc;
  endtask

  task automatic push(input int a, input int b, input int rel_cyc);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.cyc = rel + rel_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int n);
    int budget = 0;
    while ((cyc - rel) < n && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
  endtask

  task automatic finish_scn();
    int budget = 0;
    while (sb.size() > 0 && budget < 200) begin
      @(negedge clk);
      #2;
      budget++;
    end
    check("drain_remaining", sb.size(), 0);
    sb.delete();
    bus.enable = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int tri_seq [8] = '{0, 1024, 2048, 3072, 4094, 3070, 2046, 1022};
  int sync_a  [7] = '{0, 1024, 2048, 0, 0, 1024, 2048};
  int sync_b  [7] = '{0, 256, 512, 0, 0, 256, 512};

  initial begin
    bus.enable   = 1'b0;
    bus.sync     = 1'b0;
    bus.mode_a   = 2'd0;
    bus.mode_b   = 2'd0;
    bus.freq_a   = '0;
    bus.freq_b   = '0;
    bus.amp_a    = '0;
    bus.amp_b    = '0;
    bus.offset_a = '0;
    bus.offset_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_dacA", int'(bus.dacA_out), 2048);
    check("reset_dacB", int'(bus.dacB_out), 2048);
    check("reset_valid", int'(bus.sample_valid), 0);

    // DC, then reset one cycle before the fourth strobe
    start_scn(2'd0, 32'h0, 12'd4095, 12'd1000, 2'd2, 32'h1000_0000, 12'd0, 12'd77);
    for (int k = 0; k < 3; k++) push(1000, 77, 6 + 4 * k);
    wait_until(17);
    rst_n = 1'b0;
    check("dc_all_strobes_seen", sb.size(), 0);
    sb.delete();
    repeat (4) begin
      @(negedge clk);
      #1;
      check("inreset_dacA", int'(bus.dacA_out), 2048);
      check("inreset_valid", int'(bus.sample_valid), 0);
    end

    // Square (A) and saturating square (B), with an enable drop mid-pipeline
    start_scn(2'd1, 32'h8000_0000, 12'd2047, 12'd2048, 2'd1, 32'h8000_0000, 12'd4095, 12'd4000);
    push(4094, 4095, 6);
    push(1, 0, 10);
    push(4094, 4095, 14);
    wait_until(12);
    bus.enable = 1'b0;
    wait_until(29);
    #1;
    check("disabled_dacA", int'(bus.dacA_out), 4094);
    check("disabled_dacB", int'(bus.dacB_out), 4095);
    check("disabled_all_seen", sb.size(), 0);
    wait_until(30);
    bus.enable = 1'b1;
    push(1, 0, 36);
    push(4094, 4095, 40);
    push(1, 0, 44);
    finish_scn();

    // Sawtooth with wrap (A) and triangle (B)
    start_scn(2'd2, 32'h1000_0000, 12'd2048, 12'd2048, 2'd3, 32'h2000_0000, 12'd2048, 12'd2048);
    for (int k = 0; k < 17; k++) push((k % 16) * 256, tri_seq[k % 8], 6 + 4 * k);
    finish_scn();

    // Sync coincident with the fourth tick restarts both channels at zero phase
    start_scn(2'd3, 32'h2000_0000, 12'd2048, 12'd2048, 2'd2, 32'h1000_0000, 12'd2048, 12'd2048);
    for (int k = 0; k < 7; k++) push(sync_a[k], sync_b[k], 6 + 4 * k);
    wait_until(15);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    finish_scn();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
